knn_query_sched: RTL and testbench

// Query scheduler/arbiter in front of the kNN systolic core (sm_knn) and its db_rom loader.
// - Sequences database initialisation: drives the loader and the array input mux.
// - Round-robin arbitrates NREQ requesters that submit measurement vectors.
// - Runs one query at a time over the fixed systolic latency window.
// - Returns the (x,y) result, tagged with the requester id, over a valid/ready handshake.

---
 rtl/knn_query_sched.sv | 183 ++++++++++++++++++
 tb/tb_knn_query_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_query_sched.sv
// Query scheduler in front of the kNN systolic core: sequences database
// loading, round-robin arbitrates requesters, runs one query at a time over
// the fixed systolic latency and returns the tagged (x,y) result.
module knn_query_sched #(
  parameter int unsigned VECT_NUM = 36,
  parameter int unsigned VECT_LEN = 10,
  parameter int unsigned WORD_LEN = 6,
  parameter int unsigned LBL_LEN  = 14,
  parameter int unsigned K_NUM    = 3,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned INIT_TMO = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               init,
  input  logic [NREQ-1:0]                    req_valid,
  input  logic [NREQ*VECT_LEN*WORD_LEN-1:0]  req_vec,
  output logic [NREQ-1:0]                    req_ready,
  output logic                               loader_run,
  input  logic                               loader_done,
  output logic                               arr_sel_ld,
  output logic                               arr_ena,
  output logic [VECT_LEN*WORD_LEN-1:0]       arr_vec,
  input  logic [LBL_LEN/2-1:0]               arr_x,
  input  logic [LBL_LEN/2-1:0]               arr_y,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [$clog2(NREQ)-1:0]            res_id,
  output logic [LBL_LEN/2-1:0]               res_x,
  output logic [LBL_LEN/2-1:0]               res_y,
  output logic                               init_ok,
  output logic                               init_err
);

  localparam int unsigned VEC_W  = VECT_LEN * WORD_LEN;
  localparam int unsigned ID_W   = $clog2(NREQ);
  localparam int unsigned LAT    = VECT_LEN + VECT_NUM + K_NUM;
  localparam int unsigned CNT_W  = $clog2(LAT + 1);
  localparam int unsigned ICNT_W = $clog2(INIT_TMO + 1);

  typedef enum logic [2:0] {
    S_UNINIT,
    S_INIT,
    S_IDLE,
    S_WORK,
    S_RESP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ICNT_W-1:0]   icnt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     cur_id;
  logic                init_pend;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand;
  logic [VEC_W-1:0]    req_slices [NREQ];

  // Split the flat requester bus into one vector per requester
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      req_slices[i] = req_vec[i*VEC_W +: VEC_W];
    end
  end

  // Round-robin pick: first valid requester at or after the pointer, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_UNINIT;
      cnt        <= '0;
      icnt       <= '0;
      rr_ptr     <= '0;
      cur_id     <= '0;
      init_pend  <= 1'b0;
      req_ready  <= '0;
      loader_run <= 1'b0;
      arr_sel_ld <= 1'b1;
      arr_ena    <= 1'b0;
      arr_vec    <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_x      <= '0;
      res_y      <= '0;
      init_ok    <= 1'b0;
      init_err   <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        S_UNINIT: begin
          if (init) begin
            state      <= S_INIT;
            icnt       <= '0;
            loader_run <= 1'b1;
            arr_sel_ld <= 1'b1;
            init_pend  <= 1'b0;
          end
        end
        S_INIT: begin
          // loader_done takes precedence over a coincident timeout
          if (loader_done) begin
            state      <= S_IDLE;
            loader_run <= 1'b0;
            arr_sel_ld <= 1'b0;
            init_ok    <= 1'b1;
            init_err   <= 1'b0;
          end else if (icnt == ICNT_W'(INIT_TMO)) begin
            state      <= S_UNINIT;
            loader_run <= 1'b0;
            arr_sel_ld <= 1'b1;
            init_ok    <= 1'b0;
            init_err   <= 1'b1;
          end else begin
            icnt <= icnt + ICNT_W'(1);
          end
        end
        S_IDLE: begin
          if (init || init_pend) begin
            state      <= S_INIT;
            icnt       <= '0;
            loader_run <= 1'b1;
            arr_sel_ld <= 1'b1;
            init_ok    <= 1'b0;
            init_pend  <= 1'b0;
          end else if (grant_found) begin
            state     <= S_WORK;
            cnt       <= '0;
            req_ready <= NREQ'(1) << grant_idx;
            arr_vec   <= req_slices[grant_idx];
            cur_id    <= grant_idx;
            rr_ptr    <= ID_W'((32'(grant_idx) + 32'd1) % NREQ);
            arr_ena   <= 1'b1;
          end
        end
        S_WORK: begin
          if (init) begin
            init_pend <= 1'b1;
          end
          if (cnt == CNT_W'(LAT)) begin
            state   <= S_RESP;
            arr_ena <= 1'b0;
            res_x   <= arr_x;
            res_y   <= arr_y;
            res_id  <= cur_id;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (init) begin
            init_pend <= 1'b1;
          end
          // First RESP cycle raises res_valid; handshake only once it is visible
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_UNINIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_query_sched.sv
// Self-checking bench for knn_query_sched: random queries against a
// behavioural scoreboard of grant order, latency and captured results.
module tb_knn_query_sched;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned VECT_LEN = 10;
  localparam int unsigned WORD_LEN = 6;
  localparam int unsigned VW       = VECT_LEN * WORD_LEN;
  localparam int unsigned HALF     = 7;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned LAT      = 10 + 36 + 3;
  localparam int unsigned INIT_TMO = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              init = 1'b0;
  logic              loader_done = 1'b0;
  logic              res_ready = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*VW-1:0] req_vec = '0;
  logic [NREQ-1:0]   req_ready;
  logic              loader_run, arr_sel_ld, arr_ena, res_valid, init_ok, init_err;
  logic [VW-1:0]     arr_vec;
  logic [HALF-1:0]   arr_x, arr_y, res_x, res_y;
  logic [ID_W-1:0]   res_id;

  int                cyc = 0;
  int                total = 0;
  int                bad = 0;
  int unsigned       m_rr = 0;
  logic [VW-1:0]     vecs [NREQ];

  // Array results follow the cycle count so a capture time is identifiable
  assign arr_x = HALF'(cyc * 5 + 3);
  assign arr_y = HALF'(cyc * 11 + 1);

  knn_query_sched dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .req_valid   (req_valid),
    .req_vec     (req_vec),
    .req_ready   (req_ready),
    .loader_run  (loader_run),
    .loader_done (loader_done),
    .arr_sel_ld  (arr_sel_ld),
    .arr_ena     (arr_ena),
    .arr_vec     (arr_vec),
    .arr_x       (arr_x),
    .arr_y       (arr_y),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_x       (res_x),
    .res_y       (res_y),
    .init_ok     (init_ok),
    .init_err    (init_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic randomize_vecs();
    logic [VW-1:0] v;
    for (int i = 0; i < int'(NREQ); i++) begin
      v = '0;
      for (int w = 0; w < int'(VECT_LEN); w++) begin
        v = {v[VW-WORD_LEN-1:0], WORD_LEN'($urandom)};
      end
      vecs[ID_W'(i)] = v;
    end
    req_vec = {vecs[3], vecs[2], vecs[1], vecs[0]};
  endtask

  task automatic finish_init(input int n);
    repeat (n) step();
    loader_done = 1'b1;
    step();
    loader_done = 1'b0;
    check("init_ok_set", 64'(init_ok), 64'(1));
    check("init_err_clr", 64'(init_err), 64'(0));
    check("loader_run_off", 64'(loader_run), 64'(0));
    check("sel_query", 64'(arr_sel_ld), 64'(0));
  endtask

  task automatic init_db(input int n);
    init = 1'b1;
    step();
    init = 1'b0;
    check("loader_run_on", 64'(loader_run), 64'(1));
    check("sel_loader", 64'(arr_sel_ld), 64'(1));
    finish_init(n);
  endtask

  // One complete query: grant, latency window, result and handshake
  task automatic run_query(input logic [NREQ-1:0] mask, input int bp, input bit pulse_init);
    int            g;
    int unsigned   j;
    int            c0;
    bit            seen;
    logic [NREQ-1:0] oh;
    logic [VW-1:0] exp_vec;
    logic [HALF-1:0] ex, ey;

    randomize_vecs();
    req_valid = mask;
    g = -1;
    for (int i = 0; i < int'(NREQ); i++) begin
      j = (m_rr + 32'(i)) % NREQ;
      if (g < 0 && mask[ID_W'(j)]) g = int'(j);
    end
    if (g < 0) g = 0;
    exp_vec = vecs[ID_W'(g)];
    oh = '0;
    oh[ID_W'(g)] = 1'b1;

    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (req_ready != '0) seen = 1'b1;
    end
    check("grant_seen", 64'(seen), 64'(1));
    if (!seen) begin
      req_valid = '0;
      return;
    end
    check("grant_onehot", 64'(req_ready), 64'(oh));
    check("arr_vec_latch", 64'(arr_vec), 64'(exp_vec));
    c0 = cyc;
    m_rr = (32'(g) + 1) % NREQ;
    randomize_vecs();

    step();
    check("ready_one_cycle", 64'(req_ready), 64'(0));
    check("arr_ena_work", 64'(arr_ena), 64'(1));

    seen = 1'b0;
    while (!seen && (cyc - c0) < int'(LAT) + 10) begin
      init = (pulse_init && (cyc - c0) == 10);
      step();
      if ((cyc - c0) == int'(LAT)) check("arr_ena_last", 64'(arr_ena), 64'(1));
      if (res_valid) seen = 1'b1;
    end
    init = 1'b0;
    check("res_seen", 64'(seen), 64'(1));
    check("latency", 64'(cyc - c0), 64'(LAT + 2));

    ex = HALF'((c0 + int'(LAT)) * 5 + 3);
    ey = HALF'((c0 + int'(LAT)) * 11 + 1);
    check("res_id", 64'(res_id), 64'(g));
    check("res_x", 64'(res_x), 64'(ex));
    check("res_y", 64'(res_y), 64'(ey));
    check("arr_vec_hold", 64'(arr_vec), 64'(exp_vec));
    check("arr_ena_resp", 64'(arr_ena), 64'(0));

    if (bp > 0) begin
      repeat (bp) step();
      check("bp_valid", 64'(res_valid), 64'(1));
      check("bp_x", 64'(res_x), 64'(ex));
      check("bp_y", 64'(res_y), 64'(ey));
      check("bp_id", 64'(res_id), 64'(g));
    end

    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("res_drop", 64'(res_valid), 64'(0));
    check("no_same_cycle_grant", 64'(req_ready), 64'(0));
    if (pulse_init) req_valid = '0;
  endtask

  initial begin
    int c;
    bit seen;

    // Reset state
    step();
    check("rst_sel", 64'(arr_sel_ld), 64'(1));
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_run", 64'(loader_run), 64'(0));
    check("rst_ena", 64'(arr_ena), 64'(0));
    check("rst_valid", 64'(res_valid), 64'(0));
    check("rst_ok", 64'(init_ok), 64'(0));
    check("rst_err", 64'(init_err), 64'(0));
    reset = 1'b0;

    // Requests before any database load are never granted
    req_valid = '1;
    repeat (100) begin
      step();
      check("pre_init_idle", 64'({req_ready, arr_ena}), 64'(0));
    end
    req_valid = '0;

    init_db(40);
    run_query(4'b0001, 0, 1'b0);

    // Round robin with every requester pending
    repeat (5) run_query(4'b1111, 0, 1'b0);

    // Random masks and back-pressure
    repeat (12) run_query(NREQ'($urandom_range(1, 15)), int'($urandom_range(0, 4)), 1'b0);
    req_valid = '0;

    // Long back-pressure with an init arriving mid-query
    run_query(NREQ'($urandom_range(1, 15)), 20, 1'b1);
    step();
    check("pend_init_run", 64'(loader_run), 64'(1));
    check("pend_init_ok_clr", 64'(init_ok), 64'(0));
    check("pend_init_sel", 64'(arr_sel_ld), 64'(1));
    finish_init(15);

    // Init timeout; a second init pulse mid-INIT must not restart the count
    init = 1'b1;
    step();
    init = 1'b0;
    c = cyc;
    check("tmo_run", 64'(loader_run), 64'(1));
    while (loader_run && (cyc - c) < 300) begin
      init = ((cyc - c) == 100);
      step();
      if ((cyc - c) == 250) check("tmo_early", 64'(init_err), 64'(0));
    end
    init = 1'b0;
    check("tmo_window", 64'((cyc - c) >= int'(INIT_TMO) && (cyc - c) <= int'(INIT_TMO) + 2), 64'(1));
    check("tmo_err", 64'(init_err), 64'(1));
    check("tmo_ok", 64'(init_ok), 64'(0));
    check("tmo_sel", 64'(arr_sel_ld), 64'(1));
    req_valid = '1;
    repeat (5) begin
      step();
      check("tmo_no_grant", 64'(req_ready), 64'(0));
    end
    req_valid = '0;
    init_db(10);
    run_query(4'b1111, 3, 1'b0);
    req_valid = '0;

    // Asynchronous reset in the middle of a query
    req_valid = '1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (req_ready != '0) seen = 1'b1;
    end
    check("rst_q_grant", 64'(seen), 64'(1));
    c = cyc;
    while ((cyc - c) < 20) step();
    #2 reset = 1'b1;
    #1;
    check("arst_ena", 64'(arr_ena), 64'(0));
    check("arst_valid", 64'(res_valid), 64'(0));
    check("arst_ok", 64'(init_ok), 64'(0));
    check("arst_sel", 64'(arr_sel_ld), 64'(1));
    step();
    reset = 1'b0;
    m_rr = 0;
    repeat (5) begin
      step();
      check("post_rst_no_grant", 64'(req_ready), 64'(0));
    end
    req_valid = '0;
    init_db(12);
    run_query(4'b1111, 2, 1'b0);
    req_valid = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
